// File: rtl/string_writer_pkg.sv
// Shared types and character constants for the parametrised UART string writer.
package string_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SEND,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TAIL_NONE,
        TAIL_CR,
        TAIL_LF
    } tail_t;

    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte when idle (valid && ready) and shifts it out LSB first.
module uart_tx #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);
    localparam int         CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CYC_LAST = 16'(CYCLE - 1);

    logic        busy_q, busy_d;
    logic [15:0] cyc_q, cyc_d;
    logic [3:0]  bit_q, bit_d;
    logic [8:0]  shift_q, shift_d;
    logic        pin_q, pin_d;

    always_comb begin
        busy_d  = busy_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pin_d   = pin_q;
        if (!busy_q) begin
            if (tx_data_valid) begin
                busy_d  = 1'b1;
                shift_d = {1'b1, tx_data};
                pin_d   = 1'b0;
                cyc_d   = '0;
                bit_d   = '0;
            end
        end else if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            // bit 0 is the start bit, 1..8 data, 9 the stop bit
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                pin_d   = shift_q[0];
                shift_d = {1'b1, shift_q[8:1]};
                bit_d   = bit_q + 4'd1;
            end
        end else begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            pin_q   <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
        end
    end

    assign tx_data_ready = !busy_q;
    assign tx_pin        = pin_q;

endmodule

// File: rtl/string_writer_p.sv
// Streams a latched, NUL-terminated byte-packed string through uart_tx.
// Define STRING_WRITER_CRLF_EN to append CR LF after every string (including empty ones).
module string_writer_p
    import string_writer_pkg::*;
#(
    parameter int MAX_CHARS = 80,
    parameter int LSB_FIRST = 0,
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [8*MAX_CHARS-1:0]         line,
    input  logic                           send,
    output logic                           ready,
    output logic                           done,
    output logic [$clog2(MAX_CHARS+1)-1:0] length,
    output logic                           uart_tx,
    input  logic                           uart_rx
);
    localparam int             IW      = $clog2(MAX_CHARS + 1);
    localparam logic [IW-1:0]  MAX_IDX = IW'(MAX_CHARS);
    localparam logic [IW-1:0]  ONE     = IW'(1);

    state_t                 state_q, state_d;
    logic [8*MAX_CHARS-1:0] buffer_q, buffer_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          length_q, length_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_data_valid_q, tx_data_valid_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   tx_data_ready;
    logic [7:0]             scan_byte;
    logic [7:0]             ptr_byte;
    logic [7:0]             send_byte;
    logic                   last_byte;
    logic                   unused_rx;
`ifdef STRING_WRITER_CRLF_EN
    tail_t                  tail_q, tail_d;
`endif

    assign unused_rx = uart_rx;

    // Reads past the buffer end look like a terminator, so a full string stops cleanly.
    assign scan_byte = (idx_q < MAX_IDX) ? buffer_q[{idx_q, 3'b000} +: 8] : CHAR_NUL;
    assign ptr_byte  = buffer_q[{ptr_q, 3'b000} +: 8];
    assign last_byte = (LSB_FIRST != 0) ? (ptr_q == length_q - ONE) : (ptr_q == '0);

`ifdef STRING_WRITER_CRLF_EN
    assign send_byte = (tail_q == TAIL_CR) ? CHAR_CR :
                       (tail_q == TAIL_LF) ? CHAR_LF : ptr_byte;
`else
    assign send_byte = ptr_byte;
`endif

    always_comb begin
        state_d         = state_q;
        buffer_d        = buffer_q;
        idx_d           = idx_q;
        ptr_d           = ptr_q;
        length_d        = length_q;
        tx_data_d       = tx_data_q;
        tx_data_valid_d = tx_data_valid_q;
        ready_d         = ready_q;
        done_d          = 1'b0;
`ifdef STRING_WRITER_CRLF_EN
        tail_d          = tail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    buffer_d = line;
                    idx_d    = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_SCAN;
`ifdef STRING_WRITER_CRLF_EN
                    tail_d   = TAIL_NONE;
`endif
                end
            end
            ST_SCAN: begin
                if (scan_byte != CHAR_NUL) begin
                    idx_d = idx_q + ONE;
                end else begin
                    length_d = idx_q;
                    if (idx_q == '0) begin
`ifdef STRING_WRITER_CRLF_EN
                        tail_d  = TAIL_CR;
                        state_d = ST_SEND;
`else
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        ptr_d   = (LSB_FIRST != 0) ? '0 : idx_q - ONE;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                tx_data_d       = send_byte;
                tx_data_valid_d = 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_data_valid_q && tx_data_ready) begin
                    tx_data_valid_d = 1'b0;
                    state_d         = ST_SEND;
`ifdef STRING_WRITER_CRLF_EN
                    if (tail_q == TAIL_LF) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tail_q == TAIL_CR) begin
                        tail_d = TAIL_LF;
                    end else if (last_byte) begin
                        tail_d = TAIL_CR;
                    end else begin
                        ptr_d = (LSB_FIRST != 0) ? ptr_q + ONE : ptr_q - ONE;
                    end
`else
                    if (last_byte) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = (LSB_FIRST != 0) ? ptr_q + ONE : ptr_q - ONE;
                    end
`endif
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            buffer_q        <= '0;
            idx_q           <= '0;
            ptr_q           <= '0;
            length_q        <= '0;
            tx_data_q       <= '0;
            tx_data_valid_q <= 1'b0;
            ready_q         <= 1'b1;
            done_q          <= 1'b0;
`ifdef STRING_WRITER_CRLF_EN
            tail_q          <= TAIL_NONE;
`endif
        end else begin
            state_q         <= state_d;
            buffer_q        <= buffer_d;
            idx_q           <= idx_d;
            ptr_q           <= ptr_d;
            length_q        <= length_d;
            tx_data_q       <= tx_data_d;
            tx_data_valid_q <= tx_data_valid_d;
            ready_q         <= ready_d;
            done_q          <= done_d;
`ifdef STRING_WRITER_CRLF_EN
            tail_q          <= tail_d;
`endif
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign length = length_q;

    uart_tx #(
        .CLK_FRE  (CLK_FRE),
        .BAUD_RATE(BAUD_RATE)
    ) u_uart_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data_q),
        .tx_data_valid(tx_data_valid_q),
        .tx_data_ready(tx_data_ready),
        .tx_pin       (uart_tx)
    );

endmodule

// File: tb/tb_string_writer_p.sv
// Bench for string_writer_p: two instances (MSB-first 8 chars, LSB-first 4 chars), UART line decoded back to bytes.
module tb_string_writer_p;

    localparam int M0  = 8;
    localparam int M1  = 4;
    localparam int BIT = 8;

    typedef logic [7:0] seq_t [0:19];

    typedef struct {
        int          w;
        logic [63:0] ln;
        int          exp_len;
        int          exp_n;
        logic [63:0] exp_seq;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [63:0] line0 = '0;
    logic [31:0] line1 = '0;
    logic send0 = 1'b0, send1 = 1'b0;
    logic ready0, ready1, done0, done1, tx0, tx1;
    logic [$clog2(M0+1)-1:0] len0;
    logic [$clog2(M1+1)-1:0] len1;

    int checks = 0;
    int failures = 0;
    int dcnt0 = 0, dcnt1 = 0;
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];

    always #5 clk = ~clk;

    string_writer_p #(.MAX_CHARS(M0), .LSB_FIRST(0), .CLK_FRE(1), .BAUD_RATE(125000)) dut0 (
        .clk(clk), .rst_n(rst_n), .line(line0), .send(send0), .ready(ready0),
        .done(done0), .length(len0), .uart_tx(tx0), .uart_rx(1'b1));

    string_writer_p #(.MAX_CHARS(M1), .LSB_FIRST(1), .CLK_FRE(1), .BAUD_RATE(125000)) dut1 (
        .clk(clk), .rst_n(rst_n), .line(line1), .send(send1), .ready(ready1),
        .done(done1), .length(len1), .uart_tx(tx1), .uart_rx(1'b1));

    always @(posedge clk) begin
        if (done0 === 1'b1) dcnt0 <= dcnt0 + 1;
        if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic pin(input int w);
        return (w == 0) ? tx0 : tx1;
    endfunction
    function automatic logic rdy(input int w);
        return (w == 0) ? ready0 : ready1;
    endfunction
    function automatic int dcnt(input int w);
        return (w == 0) ? dcnt0 : dcnt1;
    endfunction
    function automatic int qsize(input int w);
        return (w == 0) ? rxq0.size() : rxq1.size();
    endfunction
    function automatic int lenv(input int w);
        return (w == 0) ? int'(len0) : int'(len1);
    endfunction

    // Serial receiver: samples at mid-bit, 8 cycles per bit.
    task automatic rx_frame(input int w, output logic [7:0] b);
        do @(negedge clk); while (pin(w) !== 1'b0);
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = pin(w);
        end
        repeat (BIT) @(negedge clk);
        check($sformatf("stop_bit_dut%0d", w), 64'(pin(w)), 64'd1);
    endtask

    initial begin : rx0
        logic [7:0] b;
        forever begin rx_frame(0, b); rxq0.push_back(b); end
    end
    initial begin : rx1
        logic [7:0] b;
        forever begin rx_frame(1, b); rxq1.push_back(b); end
    end

    // Reference: string = bytes from 0 up to the first NUL (or MAX), emitted in text order.
    function automatic void model(input int w, input logic [63:0] ln, output int len,
                                  output seq_t seq, output int n);
        int maxc;
        logic [7:0] chars [0:7];
        maxc = (w == 0) ? M0 : M1;
        for (int i = 0; i < 20; i++) seq[i] = '0;
        for (int i = 0; i < 8; i++) chars[i] = ln[8*i +: 8];
        len = 0;
        while (len < maxc && chars[len] != 8'h00) len++;
        n = 0;
        for (int k = 0; k < len; k++) begin
            seq[n] = (w == 1) ? chars[k] : chars[len-1-k];
            n++;
        end
`ifdef STRING_WRITER_CRLF_EN
        seq[n] = 8'h0D; n++;
        seq[n] = 8'h0A; n++;
`endif
    endfunction

    task automatic start_txn(input int w, input logic [63:0] ln);
        int t = 0;
        while (rdy(w) !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (w == 0) begin line0 = ln; send0 = 1'b1; end
        else begin line1 = ln[31:0]; send1 = 1'b1; end
        @(negedge clk);
        send0 = 1'b0;
        send1 = 1'b0;
    endtask

    task automatic finish_txn(input int w, input string tag, input int d0, input int exp_done,
                              input int exp_len, input seq_t e, input int n);
        int t = 0;
        logic [7:0] got;
        while ((dcnt(w) - d0 < exp_done || rdy(w) !== 1'b1 || qsize(w) < n) && t < 4000) begin
            @(negedge clk); t++;
        end
        check({tag, "_timeout"}, 64'(t < 4000), 64'd1);
        repeat (120) @(negedge clk);
        check({tag, "_len"}, 64'(lenv(w)), 64'(exp_len));
        check({tag, "_done_count"}, 64'(dcnt(w) - d0), 64'(exp_done));
        check({tag, "_byte_count"}, 64'(qsize(w)), 64'(n));
        check({tag, "_ready"}, 64'(rdy(w)), 64'd1);
        for (int k = 0; k < n; k++) begin
            got = 'x;
            if (w == 0 && rxq0.size() > 0) got = rxq0.pop_front();
            if (w == 1 && rxq1.size() > 0) got = rxq1.pop_front();
            check($sformatf("%s_byte%0d", tag, k), 64'(got), 64'(e[k]));
        end
        rxq0.delete();
        rxq1.delete();
        $display("txn %s dut%0d len=%0d bytes=%0d", tag, w, exp_len, n);
    endtask

    task automatic run_txn(input int w, input string tag, input logic [63:0] ln,
                           input int exp_len, input seq_t e, input int n);
        int d0;
        d0 = dcnt(w);
        start_txn(w, ln);
        finish_txn(w, tag, d0, 1, exp_len, e, n);
    endtask

    vec_t tbl [0:7];

    initial begin : main
        seq_t e, e2;
        int n, n2, ln_exp, d0, t;
        logic [63:0] sv, rl;
        logic low_seen;

        tbl[0] = '{0, 64'h4849,               2, 2, 64'h4948};
        tbl[1] = '{1, 64'h0000_4241,          2, 2, 64'h4241};
        tbl[2] = '{0, 64'h0,                  0, 0, 64'h0};
        tbl[3] = '{0, 64'h3132333435363738,   8, 8, 64'h3837363534333231};
        tbl[4] = '{1, 64'h3132_3334,          4, 4, 64'h31323334};
        tbl[5] = '{0, 64'h0000_4142_0043_4445, 3, 3, 64'h454443};
        tbl[6] = '{1, 64'h4142_4300,          0, 0, 64'h0};
        tbl[7] = '{1, 64'h0063_6261,          3, 3, 64'h636261};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready0", 64'(ready0), 64'd1);
        check("reset_done0", 64'(done0), 64'd0);
        check("reset_len0", 64'(len0), 64'd0);
        check("reset_tx0", 64'(tx0), 64'd1);
        check("reset_ready1", 64'(ready1), 64'd1);
        check("reset_len1", 64'(len1), 64'd0);
        check("reset_tx1", 64'(tx1), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sv = tbl[i].exp_seq;
            for (int k = 0; k < 20; k++) e[k] = '0;
            for (int k = 0; k < tbl[i].exp_n; k++) e[k] = sv[8*k +: 8];
            n = tbl[i].exp_n;
`ifdef STRING_WRITER_CRLF_EN
            e[n] = 8'h0D; e[n+1] = 8'h0A; n = n + 2;
`endif
            run_txn(tbl[i].w, $sformatf("table%0d", i), tbl[i].ln, tbl[i].exp_len, e, n);
        end

`ifndef STRING_WRITER_CRLF_EN
        // Empty string: done two cycles after send, ready drops for one cycle, line stays idle.
        d0 = dcnt0;
        line0 = '0; send0 = 1'b1;
        @(negedge clk); send0 = 1'b0;
        check("empty_ready_low", 64'(ready0), 64'd0);
        check("empty_done_early", 64'(done0), 64'd0);
        @(negedge clk);
        check("empty_done_pulse", 64'(done0), 64'd1);
        check("empty_ready_back", 64'(ready0), 64'd1);
        low_seen = 1'b0;
        repeat (60) begin @(negedge clk); if (tx0 !== 1'b1) low_seen = 1'b1; end
        check("empty_line_idle", 64'(low_seen), 64'd0);
        check("empty_done_once", 64'(dcnt0 - d0), 64'd1);
        $display("txn empty_timing dut0 len=0 bytes=0");
`endif

        // send during transmission is ignored
        model(0, 64'h4849, ln_exp, e, n);
        d0 = dcnt0;
        start_txn(0, 64'h4849);
        t = 0;
        while (tx0 !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        line0 = 64'h5a5a; send0 = 1'b1;
        @(negedge clk); send0 = 1'b0;
        finish_txn(0, "ignore_send", d0, 1, ln_exp, e, n);

        // done and a new send in the same cycle
        model(1, 64'h4241, ln_exp, e, n);
        model(1, 64'h4443, ln_exp, e2, n2);
        for (int k = 0; k < n2; k++) e[n+k] = e2[k];
        d0 = dcnt1;
        start_txn(1, 64'h4241);
        t = 0;
        while (done1 !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        check("same_cycle_ready", 64'(ready1), 64'd1);
        line1 = 32'h4443; send1 = 1'b1;
        @(negedge clk); send1 = 1'b0;
        finish_txn(1, "same_cycle", d0, 2, ln_exp, e, n + n2);

        // reset during the second byte of "ABC"
        d0 = dcnt0;
        start_txn(0, 64'h414243);
        t = 0;
        while (rxq0.size() < 1 && t < 1000) begin @(negedge clk); t++; end
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ready0), 64'd1);
        check("midrst_done", 64'(done0), 64'd0);
        check("midrst_tx_idle", 64'(tx0), 64'd1);
        check("midrst_len", 64'(len0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low_seen = 1'b0;
        repeat (150) begin @(negedge clk); if (tx0 !== 1'b1) low_seen = 1'b1; end
        check("midrst_line_quiet", 64'(low_seen), 64'd0);
        check("midrst_no_done", 64'(dcnt0 - d0), 64'd0);
        rxq0.delete();
        $display("txn midrst dut0 len=3 bytes=partial");

        // randomized strings against the reference model
        for (int i = 0; i < 24; i++) begin
            int w, maxc, pos;
            w = i % 2;
            maxc = (w == 0) ? M0 : M1;
            rl = '0;
            for (int k = 0; k < 8; k++) rl[8*k +: 8] = 8'($urandom_range(1, 255));
            pos = $urandom_range(0, maxc);
            if (pos < maxc) rl[8*pos +: 8] = 8'h00;
            model(w, rl, ln_exp, e, n);
            run_txn(w, $sformatf("rand%0d", i), rl, ln_exp, e, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

endmodule
